asy_down_counter_core: RTL and testbench

- Synchronous free-running binary down counter. Its default is 2 bits.
- Used as a small timebase or sequence generator. It replaces the legacy ripple (asynchronous) down counter with a single-clock equivalent; the count sequence is identical, with no ripple delay.
- Also provides status outputs: zero detect, wrap (borrow) pulse, and per-bit toggle mask.

---
 rtl/asy_down_counter_core_if.sv | 33 +++
 rtl/asy_down_counter_core.sv | 69 ++++++
 tb/tb_asy_down_counter_core.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/asy_down_counter_core_if.sv
// rtl/asy_down_counter_core_if.sv - status/count bundle of the synchronous down counter
//
// Purpose : groups the counter outputs so producer and consumers share one port.
// Signals : q      [WIDTH-1:0] current count (registered)
//           zero               high while q == 0
//           borrow             registered wrap pulse (saturation level when enabled)
//           tog    [WIDTH-1:0] registered mask of q bits flipped on the last update
// Modports: master drives all signals (the counter), slave observes them.

interface asy_down_counter_core_if #(
  parameter int WIDTH = 2
);

  logic [WIDTH-1:0] q;
  logic             zero;
  logic             borrow;
  logic [WIDTH-1:0] tog;

  modport master (
    output q,
    output zero,
    output borrow,
    output tog
  );

  modport slave (
    input q,
    input zero,
    input borrow,
    input tog
  );

endinterface

// File: rtl/asy_down_counter_core.sv
// rtl/asy_down_counter_core.sv - synchronous free-running binary down counter with status outputs
//
// Purpose : single-clock replacement for a ripple down counter; same count
//           sequence, no ripple delay. Provides zero detect, borrow pulse and
//           a per-bit toggle mask.
// Params  : WIDTH     counter width, 1..16
//           RESET_VAL value loaded on reset (truncated to WIDTH bits)
// Ports   : clk  rising-edge clock
//           rst  synchronous active-high reset, priority over counting
//           bus  asy_down_counter_core_if.master: q, zero, borrow, tog
// Macro   : ASY_DOWN_COUNTER_SAT_EN - when defined the counter saturates at 0
//           (q holds, borrow stays high as a level, tog = 0) instead of wrapping.

module asy_down_counter_core #(
  parameter int WIDTH     = 2,
  parameter int RESET_VAL = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  asy_down_counter_core_if.master        bus
);

  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] tog_q, tog_d;
  logic             borrow_q, borrow_d;
  logic             q_is_zero;

  assign q_is_zero = (q_q == '0);

  // Ripple-down equivalence: bit i flips when every lower bit of the old
  // value is 0, i.e. when a borrow propagates through them. The new count is
  // the old count with exactly those bits inverted.
  always_comb begin
    tog_d    = '0;
    tog_d[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      tog_d[i] = tog_d[i-1] & ~q_q[i-1];
    end
    // Old value 0 means the borrow runs off the top bit: this is the wrap.
    borrow_d = q_is_zero;
`ifdef ASY_DOWN_COUNTER_SAT_EN
    // Saturate: suppress every flip once the count has reached 0.
    if (q_is_zero) begin
      tog_d = '0;
    end
`endif
    q_d = q_q ^ tog_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q      <= RST_Q;
      tog_q    <= '0;
      borrow_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      tog_q    <= tog_d;
      borrow_q <= borrow_d;
    end
  end

  assign bus.q      = q_q;
  assign bus.zero   = q_is_zero;
  assign bus.borrow = borrow_q;
  assign bus.tog    = tog_q;

endmodule

// File: tb/tb_asy_down_counter_core.sv
// tb/tb_asy_down_counter_core.sv - directed vector bench for asy_down_counter_core

module tb_asy_down_counter_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;  // WIDTH=2 RESET_VAL=0
  logic rst_b = 1'b1;  // WIDTH=2 RESET_VAL=2
  logic rst_c = 1'b1;  // WIDTH=4 RESET_VAL=0
  logic rst_d = 1'b1;  // WIDTH=2 RESET_VAL=1

  asy_down_counter_core_if #(.WIDTH(2)) if_a ();
  asy_down_counter_core_if #(.WIDTH(2)) if_b ();
  asy_down_counter_core_if #(.WIDTH(4)) if_c ();
  asy_down_counter_core_if #(.WIDTH(2)) if_d ();

  asy_down_counter_core #(.WIDTH(2), .RESET_VAL(0)) dut_a (.clk(clk), .rst(rst_a), .bus(if_a.master));
  asy_down_counter_core #(.WIDTH(2), .RESET_VAL(2)) dut_b (.clk(clk), .rst(rst_b), .bus(if_b.master));
  asy_down_counter_core #(.WIDTH(4), .RESET_VAL(0)) dut_c (.clk(clk), .rst(rst_c), .bus(if_c.master));
  asy_down_counter_core #(.WIDTH(2), .RESET_VAL(1)) dut_d (.clk(clk), .rst(rst_d), .bus(if_d.master));

  typedef struct {
    logic       rst;
    logic [1:0] q;
    logic       zero;
    logic       borrow;
    logic [1:0] tog;
  } vec_t;

  vec_t vecs[14];
  int   applied = 0;
  int   errors  = 0;

  task automatic chk(input string name, input int idx, input logic [15:0] got, input logic [15:0] exp);
    applied++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] eb_q[4], eb_t[4], ed_q[4], ed_t[4];
    logic       eb_b[4], ed_b[4];
    logic [3:0] ec_q, ec_q_old;

`ifndef ASY_DOWN_COUNTER_SAT_EN
    vecs[0]  = '{1'b1, 2'd0, 1'b1, 1'b0, 2'b00};
    vecs[1]  = '{1'b1, 2'd0, 1'b1, 1'b0, 2'b00};
    vecs[2]  = '{1'b0, 2'd3, 1'b0, 1'b1, 2'b11};
    vecs[3]  = '{1'b0, 2'd2, 1'b0, 1'b0, 2'b01};
    vecs[4]  = '{1'b0, 2'd1, 1'b0, 1'b0, 2'b11};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 1'b0, 2'b01};
    vecs[6]  = '{1'b0, 2'd3, 1'b0, 1'b1, 2'b11};
    vecs[7]  = '{1'b0, 2'd2, 1'b0, 1'b0, 2'b01};
    vecs[8]  = '{1'b0, 2'd1, 1'b0, 1'b0, 2'b11};
    vecs[9]  = '{1'b0, 2'd0, 1'b1, 1'b0, 2'b01};
    vecs[10] = '{1'b0, 2'd3, 1'b0, 1'b1, 2'b11};
    vecs[11] = '{1'b0, 2'd2, 1'b0, 1'b0, 2'b01};
    vecs[12] = '{1'b1, 2'd0, 1'b1, 1'b0, 2'b00};
    vecs[13] = '{1'b0, 2'd3, 1'b0, 1'b1, 2'b11};
    eb_q = '{2'd1, 2'd0, 2'd3, 2'd2};
    eb_t = '{2'b11, 2'b01, 2'b11, 2'b01};
    eb_b = '{1'b0, 1'b0, 1'b1, 1'b0};
    ed_q = '{2'd0, 2'd3, 2'd2, 2'd1};
    ed_t = '{2'b01, 2'b11, 2'b01, 2'b11};
    ed_b = '{1'b0, 1'b1, 1'b0, 1'b0};
`else
    vecs[0]  = '{1'b1, 2'd0, 1'b1, 1'b0, 2'b00};
    vecs[1]  = '{1'b1, 2'd0, 1'b1, 1'b0, 2'b00};
    for (int i = 2; i < 12; i++) vecs[i] = '{1'b0, 2'd0, 1'b1, 1'b1, 2'b00};
    vecs[12] = '{1'b1, 2'd0, 1'b1, 1'b0, 2'b00};
    vecs[13] = '{1'b0, 2'd0, 1'b1, 1'b1, 2'b00};
    eb_q = '{2'd1, 2'd0, 2'd0, 2'd0};
    eb_t = '{2'b11, 2'b01, 2'b00, 2'b00};
    eb_b = '{1'b0, 1'b0, 1'b1, 1'b1};
    ed_q = '{2'd0, 2'd0, 2'd0, 2'd0};
    ed_t = '{2'b01, 2'b00, 2'b00, 2'b00};
    ed_b = '{1'b0, 1'b1, 1'b1, 1'b1};
`endif

    // Table: reset, free count over two wraps, mid-count reset and release.
    for (int i = 0; i < 14; i++) begin
      rst_a = vecs[i].rst;
      step();
      chk("a_q",      i, 16'(if_a.q),      16'(vecs[i].q));
      chk("a_zero",   i, 16'(if_a.zero),   16'(vecs[i].zero));
      chk("a_borrow", i, 16'(if_a.borrow), 16'(vecs[i].borrow));
      chk("a_tog",    i, 16'(if_a.tog),    16'(vecs[i].tog));
    end
    rst_a = 1'b1;

    // Non-zero reset value: 2 -> 1 -> 0 -> 3 -> 2 (zero only on 0).
    chk("b_rst_q", 0, 16'(if_b.q), 16'd2);
    chk("b_rst_zero", 0, 16'(if_b.zero), 16'd0);
    rst_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("b_q",      i, 16'(if_b.q),      16'(eb_q[i]));
      chk("b_zero",   i, 16'(if_b.zero),   16'(eb_q[i] == 2'd0));
      chk("b_borrow", i, 16'(if_b.borrow), 16'(eb_b[i]));
      chk("b_tog",    i, 16'(if_b.tog),    16'(eb_t[i]));
    end
    rst_b = 1'b1;

    // Width 4: 17 edges from 0 wrap to 15 on edge 1 and edge 17.
    chk("c_rst_q", 0, 16'(if_c.q), 16'd0);
    rst_c = 1'b0;
    ec_q = 4'd0;
    for (int k = 1; k <= 17; k++) begin
      ec_q_old = ec_q;
`ifndef ASY_DOWN_COUNTER_SAT_EN
      ec_q = ec_q - 4'd1;
`endif
      step();
      chk("c_q",      k, 16'(if_c.q),    16'(ec_q));
      chk("c_zero",   k, 16'(if_c.zero), 16'(ec_q == 4'd0));
      chk("c_borrow", k, 16'(if_c.borrow), 16'(ec_q_old == 4'd0));
      chk("c_tog",    k, 16'(if_c.tog),  16'(ec_q_old ^ ec_q));
`ifndef ASY_DOWN_COUNTER_SAT_EN
      if (k == 1 || k == 17) chk("c_wrap_tog", k, 16'(if_c.tog), 16'hF);
`endif
    end
    rst_c = 1'b1;

    // RESET_VAL=1: saturation case when enabled, plain wrap otherwise; then reset clears borrow.
    chk("d_rst_q", 0, 16'(if_d.q), 16'd1);
    rst_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("d_q",      i, 16'(if_d.q),      16'(ed_q[i]));
      chk("d_borrow", i, 16'(if_d.borrow), 16'(ed_b[i]));
      chk("d_tog",    i, 16'(if_d.tog),    16'(ed_t[i]));
    end
    rst_d = 1'b1;
    step();
    chk("d_rel_q",      0, 16'(if_d.q),      16'd1);
    chk("d_rel_borrow", 0, 16'(if_d.borrow), 16'd0);
    chk("d_rel_tog",    0, 16'(if_d.tog),    16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule
